// File: rtl/z80_int_ctrl_if.sv
// Z80 bus, interrupt and NMI signals shared by the CPU side and the interrupt controller.
// Names follow the board schematic; strobes and INT/NMI are active-low.
interface z80_int_ctrl_if;
  logic [7:0] A_LO;
  logic [7:0] D_IN;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic       IORQ;
  logic       M1;
  logic       RD;
  logic       WR;
  logic       U_INT;
  logic       NMI_BTN;
  logic       INT;
  logic       NMI;

  modport master (
    output A_LO, D_IN, IORQ, M1, RD, WR, U_INT, NMI_BTN,
    input  D_OUT, D_OE, INT, NMI
  );

  modport slave (
    input  A_LO, D_IN, IORQ, M1, RD, WR, U_INT, NMI_BTN,
    output D_OUT, D_OE, INT, NMI
  );
endinterface

// File: rtl/z80_int_ctrl.sv
// Z80 interrupt controller: frame tick + 16550 IRQ onto INT, IM2 vectors, mask/status port, NMI.
// Optional macro NMI_DEBOUNCE_EN adds a debounced, fixed-width NMI pulse from the panel button.
module z80_int_ctrl #(
  parameter int         TICK_DIV   = 480000,
  parameter logic [7:0] INT_PORT   = 8'hE0,
  parameter logic [7:0] VEC_BASE   = 8'hF0,
  parameter int         DEB_CYCLES = 240000,
  parameter int         NMI_PULSE  = 24
) (
  input logic           CLK_24MHz,
  input logic           RST,
  z80_int_ctrl_if.slave bus
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, RDST = 2'd2} state_t;

  // Active-low inputs packed as {IORQ, M1, RD, WR, NMI_BTN}; idle level is all ones.
  logic [4:0] low_s1, low_s2;
  logic       u_int_s1, u_int_s;
  logic       iorq_s, m1_s, rd_s, wr_s, nmi_btn_s;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      low_s1   <= '1;
      low_s2   <= '1;
      u_int_s1 <= 1'b0;
      u_int_s  <= 1'b0;
    end else begin
      low_s1   <= {bus.IORQ, bus.M1, bus.RD, bus.WR, bus.NMI_BTN};
      low_s2   <= low_s1;
      u_int_s1 <= bus.U_INT;
      u_int_s  <= u_int_s1;
    end
  end

  assign {iorq_s, m1_s, rd_s, wr_s, nmi_btn_s} = low_s2;

  state_t           state_q, state_d;
  logic [7:0]       dout_q, dout_d;
  logic             oe_q, int_q;
  logic [1:0]       mask;
  logic             tmr_pend, ovr, pend_d, ovr_d;
  logic [CNT_W-1:0] cnt;
  logic             wrap, io_wr_n, io_wr_n_q, port_hit, port_wr, wr_clr;
  logic             ack_tmr, rdst_exit;
  logic [4:0]       unused_din;

  assign wrap       = (cnt == CNT_W'(TICK_DIV - 1));
  assign io_wr_n    = iorq_s | wr_s;
  assign port_hit   = (bus.A_LO == INT_PORT);
  // Falling edge of the combined write strobe: one write per bus cycle however long it lasts.
  assign port_wr    = io_wr_n_q & ~io_wr_n & m1_s & port_hit;
  assign wr_clr     = port_wr & bus.D_IN[7];
  assign unused_din = bus.D_IN[6:2];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    ack_tmr   = 1'b0;
    rdst_exit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!m1_s && !iorq_s) begin
          state_d = ACK;
          if (tmr_pend && mask[0]) begin
            dout_d  = VEC_BASE;
            ack_tmr = 1'b1;
          end else if (u_int_s && mask[1]) begin
            dout_d = VEC_BASE | 8'h02;
          end else begin
            dout_d = VEC_BASE | 8'h04;
          end
        end else if (!iorq_s && !rd_s && m1_s && port_hit) begin
          state_d = RDST;
          dout_d  = {3'b000, mask, ovr, u_int_s, tmr_pend};
        end
      end
      ACK:  if (iorq_s) state_d = IDLE;
      RDST: begin
        if (iorq_s) begin
          state_d   = IDLE;
          rdst_exit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clears apply first; a tick wrap in the same cycle then wins.
  always_comb begin
    pend_d = tmr_pend;
    ovr_d  = ovr;
    if (ack_tmr || wr_clr) pend_d = 1'b0;
    if (wr_clr || rdst_exit) ovr_d = 1'b0;
    if (wrap) begin
      if (tmr_pend && !(ack_tmr || wr_clr)) ovr_d = 1'b1;
      else                                  pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      state_q   <= IDLE;
      dout_q    <= 8'h00;
      oe_q      <= 1'b0;
      int_q     <= 1'b1;
      mask      <= 2'b00;
      tmr_pend  <= 1'b0;
      ovr       <= 1'b0;
      cnt       <= '0;
      io_wr_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      oe_q      <= (state_d != IDLE);
      int_q     <= ~((tmr_pend & mask[0]) | (u_int_s & mask[1]));
      tmr_pend  <= pend_d;
      ovr       <= ovr_d;
      cnt       <= wrap ? '0 : cnt + 1'b1;
      io_wr_n_q <= io_wr_n;
      if (port_wr) mask <= bus.D_IN[1:0];
    end
  end

  assign bus.D_OUT = dout_q;
  assign bus.D_OE  = oe_q;
  assign bus.INT   = int_q;

`ifdef NMI_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int PUL_W = $clog2(NMI_PULSE + 1);

  logic             armed, run_match;
  logic [DEB_W-1:0] deb_cnt;
  logic [PUL_W-1:0] pul_cnt;

  // Armed: waiting for a stable-low press. Disarmed: waiting for a stable-high release.
  assign run_match = (nmi_btn_s != armed);

  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      armed   <= 1'b1;
      deb_cnt <= '0;
      pul_cnt <= '0;
    end else begin
      if (pul_cnt != '0) pul_cnt <= pul_cnt - 1'b1;
      if (!run_match) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb_cnt <= '0;
        armed   <= ~armed;
        if (armed) pul_cnt <= PUL_W'(NMI_PULSE);
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign bus.NMI = (pul_cnt == '0);
`else
  logic unused_cfg;
  assign unused_cfg = ^{DEB_CYCLES, NMI_PULSE};
  assign bus.NMI    = nmi_btn_s;
`endif

endmodule
